// File: rtl/im_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
// The CHECK state is only reachable when IM_LOADER_CHECKSUM_EN is defined.
package im_loader_pkg;

    localparam int unsigned IM_WORD_W     = 32;
    localparam int unsigned IM_BYTE_SHIFT = 2;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/im_loader_if.sv
// Control, image-stream and memory-write signals of the instruction-memory loader.
// slave is the loader side; master is the host/boot controller side.
interface im_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic                                 start;
    logic [ADDR_W:0]                      word_count;
    logic [im_loader_pkg::IM_WORD_W-1:0]  in_data;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [im_loader_pkg::IM_WORD_W-1:0]  im_DATA;
    logic [31:0]                          im_ADDR;
    logic                                 im_WE;
    logic                                 pc_RESET;
    logic                                 busy;
    logic                                 done;
    logic                                 err;

    modport master (
        output start, word_count, in_data, in_valid,
        input  in_ready, im_DATA, im_ADDR, im_WE, pc_RESET, busy, done, err
    );

    modport slave (
        input  start, word_count, in_data, in_valid,
        output in_ready, im_DATA, im_ADDR, im_WE, pc_RESET, busy, done, err
    );

endinterface

// File: rtl/im_loader_cksum.sv
// Wrapping 32-bit image checksum: cleared at load start, summed per accepted word,
// compared against the trailing word. Used only with IM_LOADER_CHECKSUM_EN.
module im_loader_cksum
    import im_loader_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 clear,
    input  logic                 add,
    input  logic [IM_WORD_W-1:0] data,
    input  logic [IM_WORD_W-1:0] expected,
    output logic                 match
);

    logic [IM_WORD_W-1:0] sum_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (add) begin
            sum_q <= sum_q + data;
        end
    end

    assign match = (sum_q == expected);

endmodule

// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: streams words into IM and holds the PC in reset
// until a complete image is in place. Optional checksum stage: IM_LOADER_CHECKSUM_EN.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input logic        CLK,
    input logic        RESET,
    im_loader_if.slave bus
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e               state_q, state_d;
    logic [ADDR_W:0]      cnt_q, cnt_d, total_q, total_d, cnt_inc;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [IM_WORD_W-1:0] data_q, data_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic                 loaded_q, loaded_d;
    logic                 in_rdy;

`ifdef IM_LOADER_CHECKSUM_EN
    logic ck_clear, ck_add, ck_match;

    im_loader_cksum u_cksum (
        .CLK      (CLK),
        .RESET    (RESET),
        .clear    (ck_clear),
        .add      (ck_add),
        .data     (bus.in_data),
        .expected (bus.in_data),
        .match    (ck_match)
    );
`endif

    // Counter is one bit wider than the address so a full-depth image never wraps to 0.
    assign cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        total_d  = total_q;
        addr_d   = addr_q;
        data_d   = data_q;
        we_d     = 1'b0;
        err_d    = err_q;
        loaded_d = loaded_q;
        in_rdy   = 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
        ck_clear = 1'b0;
        ck_add   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.word_count > DEPTH) begin
                        err_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        loaded_d = 1'b0;
                        cnt_d    = '0;
                        total_d  = bus.word_count;
                        state_d  = (bus.word_count == '0) ? StDone : StLoad;
`ifdef IM_LOADER_CHECKSUM_EN
                        ck_clear = 1'b1;
`endif
                    end
                end
            end
            StLoad: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    we_d   = 1'b1;
                    data_d = bus.in_data;
                    addr_d = cnt_q[ADDR_W-1:0];
                    cnt_d  = cnt_inc;
`ifdef IM_LOADER_CHECKSUM_EN
                    ck_add = 1'b1;
                    if (cnt_inc == total_q) state_d = StCheck;
`else
                    if (cnt_inc == total_q) state_d = StDone;
`endif
                end
            end
`ifdef IM_LOADER_CHECKSUM_EN
            StCheck: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    if (ck_match) begin
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
`endif
            StDone: begin
                loaded_d = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            total_q  <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            total_q  <= total_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            we_q     <= we_d;
            err_q    <= err_d;
            loaded_q <= loaded_d;
        end
    end

    assign bus.in_ready = in_rdy;
    assign bus.im_WE    = we_q;
    assign bus.im_DATA  = data_q;
    assign bus.im_ADDR  = 32'(addr_q) << IM_BYTE_SHIFT;
    assign bus.busy     = (state_q != StIdle);
    assign bus.done     = (state_q == StDone);
    assign bus.err      = err_q;
    assign bus.pc_RESET = RESET | (state_q != StIdle) | ~loaded_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader; expected writes are queued as words are offered
// and popped by a write monitor. Checksum scenarios run when IM_LOADER_CHECKSUM_EN is set.
module tb_im_loader;
    import im_loader_pkg::*;

    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic        CLK = 1'b0;
    logic        RESET;
    int          checks = 0;
    int          errors = 0;
    int          widx = 0;
    logic [31:0] mem [DEPTH];
    logic [63:0] exp_q [$];

    im_loader_if #(.ADDR_W(AW)) bus ();

    im_loader #(.ADDR_W(AW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    // Every memory write must match the oldest outstanding expected {addr, data}.
    always @(negedge CLK) begin : write_monitor
        logic [63:0] e;
        if (bus.im_WE === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, required no write",
                         bus.im_ADDR, bus.im_DATA);
            end else begin
                e = exp_q.pop_front();
                if ({bus.im_ADDR, bus.im_DATA} !== e) begin
                    errors++;
                    $display("FAIL write_addr_data: got %h/%h, expected %h/%h",
                             bus.im_ADDR, bus.im_DATA, e[63:32], e[31:0]);
                end
            end
            mem[bus.im_ADDR[AW+1:2]] = bus.im_DATA;
        end
    end

    task automatic do_start(input logic [AW:0] n);
        bus.start      = 1'b1;
        bus.word_count = n;
        @(posedge CLK);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input bit wr, input bit gap);
        int n = 0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        @(negedge CLK);
        while (bus.in_ready !== 1'b1 && n < 20) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready=%b, required 1", bus.in_ready);
        end else if (wr) begin
            exp_q.push_back({32'(widx) << 2, d});
            widx++;
        end
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        if (gap) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic load_image(input logic [31:0] words[$], input bit gaps, input string tag);
        logic [31:0] sum = '0;
        widx = 0;
        do_start((AW+1)'(words.size()));
        foreach (words[i]) begin
            push(words[i], 1'b1, gaps && (i != words.size() - 1));
            sum += words[i];
        end
`ifdef IM_LOADER_CHECKSUM_EN
        push(sum, 1'b0, 1'b0);
`endif
        @(negedge CLK);
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b, expected 1", tag, bus.done);
        end
        checks++;
`ifdef IM_LOADER_CHECKSUM_EN
        if (bus.im_WE !== 1'b0) begin
            errors++;
            $display("FAIL %s_trailer_nowrite: im_WE=%b, expected 0", tag, bus.im_WE);
        end
`else
        if (bus.im_WE !== 1'b1) begin
            errors++;
            $display("FAIL %s_done_with_last_write: im_WE=%b, expected 1", tag, bus.im_WE);
        end
`endif
        @(negedge CLK);
        checks++;
        if ({bus.pc_RESET, bus.done, bus.busy, bus.err} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_released: pc_RESET/done/busy/err=%b, expected 0000", tag,
                     {bus.pc_RESET, bus.done, bus.busy, bus.err});
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_all_written: pending=%0d, expected 0", tag, exp_q.size());
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET          = 1'b1;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.pc_RESET, bus.im_WE, bus.in_ready, bus.done, bus.busy, bus.err} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_flags: pc_RESET/WE/ready/done/busy/err=%b, expected 100000",
                     {bus.pc_RESET, bus.im_WE, bus.in_ready, bus.done, bus.busy, bus.err});
        end
        checks++;
        if ({bus.im_ADDR, bus.im_DATA} !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus: addr/data=%h/%h, expected 0/0", bus.im_ADDR, bus.im_DATA);
        end
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        checks++;
        if ({bus.pc_RESET, bus.in_ready, bus.busy} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_reset: pc_RESET/ready/busy=%b, expected 100",
                     {bus.pc_RESET, bus.in_ready, bus.busy});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_oversize();
        do_start((AW+1)'(DEPTH + 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({bus.err, bus.busy, bus.pc_RESET, bus.im_WE} !== 4'b1010) begin
                errors++;
                $display("FAIL oversize: err/busy/pc_RESET/WE=%b, expected 1010",
                         {bus.err, bus.busy, bus.pc_RESET, bus.im_WE});
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_single();
        logic [31:0] w [$] = '{32'h208C9000};
        load_image(w, 1'b0, "single");
        checks++;
        if (mem[0] !== 32'h208C9000) begin
            errors++;
            $display("FAIL fetch_pc0: got %h, expected 208c9000", mem[0]);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w [$] = '{32'h1, 32'h2, 32'h3, 32'h4};
        load_image(w, 1'b1, "gaps");
    endtask

    task automatic test_mid_reset();
        logic [31:0] w [$] = '{32'h5, 32'h6, 32'h7, 32'h8};
        widx = 0;
        do_start(4);
        push(32'hA, 1'b1, 1'b0);
        push(32'hB, 1'b1, 1'b0);
        @(negedge CLK);
        #1 RESET = 1'b1;
        #1;
        checks++;
        if ({bus.pc_RESET, bus.im_WE, bus.in_ready, bus.done, bus.busy, bus.err} !== 6'b100000 ||
            {bus.im_ADDR, bus.im_DATA} !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b addr=%h data=%h, expected 100000/0/0",
                     {bus.pc_RESET, bus.im_WE, bus.in_ready, bus.done, bus.busy, bus.err},
                     bus.im_ADDR, bus.im_DATA);
        end
        checks++;
        if (mem[0] !== 32'hA || mem[1] !== 32'hB) begin
            errors++;
            $display("FAIL mid_reset_kept: got %h %h, expected a b", mem[0], mem[1]);
        end
        @(posedge CLK);
        #1 RESET = 1'b0;
        load_image(w, 1'b0, "reload");
    endtask

    task automatic test_zero();
        do_start(0);
        @(negedge CLK);
        checks++;
        if ({bus.done, bus.im_WE, bus.pc_RESET} !== 3'b101) begin
            errors++;
            $display("FAIL zero_count: done/WE/pc_RESET=%b, expected 101",
                     {bus.done, bus.im_WE, bus.pc_RESET});
        end
        @(negedge CLK);
        checks++;
        if ({bus.done, bus.pc_RESET} !== 2'b00) begin
            errors++;
            $display("FAIL zero_release: done/pc_RESET=%b, expected 00", {bus.done, bus.pc_RESET});
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [$];
        for (int i = 0; i < int'(DEPTH); i++) w.push_back($urandom);
        load_image(w, 1'b0, "full_depth");
        checks++;
        if (mem[DEPTH-1] !== w[DEPTH-1] || mem[0] !== w[0]) begin
            errors++;
            $display("FAIL full_depth_ends: got %h %h, expected %h %h",
                     mem[0], mem[DEPTH-1], w[0], w[DEPTH-1]);
        end
    endtask

`ifdef IM_LOADER_CHECKSUM_EN
    task automatic test_cksum();
        logic [31:0] w [$] = '{32'h10, 32'h20};
        load_image(w, 1'b0, "cksum_ok");
        widx = 0;
        do_start(2);
        push(32'h10, 1'b1, 1'b0);
        push(32'h20, 1'b1, 1'b0);
        push(32'h31, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if ({bus.err, bus.done, bus.pc_RESET, bus.busy} !== 4'b1010) begin
                errors++;
                $display("FAIL cksum_bad: err/done/pc_RESET/busy=%b, expected 1010",
                         {bus.err, bus.done, bus.pc_RESET, bus.busy});
            end
        end
        @(posedge CLK);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_oversize();
        test_single();
        test_gaps();
        test_mid_reset();
        test_zero();
        test_back_to_back();
`ifdef IM_LOADER_CHECKSUM_EN
        test_cksum();
`endif
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_queue: pending=%0d, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
